// File: rtl/regfile_pkg.sv
// Shared defaults for the pipelined register file with scoreboard.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
package regfile_pkg;

    localparam int          XLEN_DEF       = 32;
    localparam int          NREGS_DEF      = 32;
    localparam int          NUM_RPORTS_DEF = 2;
    localparam int          AW_DEF         = $clog2(NREGS_DEF);
    localparam int          SP_INDEX_DEF   = 2;
    localparam int unsigned SP_INIT_DEF    = 32'h0000_2ffc;
    localparam int          HALT_REG_DEF   = 17;
    localparam int unsigned HALT_CODE_DEF  = 32'd10;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue/read/writeback bundle between the pipeline and the register file.
interface regfile_if #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NUM_RPORTS = 2
);
    logic [NUM_RPORTS*AW-1:0]   rs_addr;
    logic [NUM_RPORTS*XLEN-1:0] rs_dout;
    logic [NUM_RPORTS-1:0]      rs_busy;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [XLEN-1:0]            wr_data;
    logic                       iss_valid;
    logic [AW-1:0]              iss_rd;
    logic                       is_ecall;
    logic                       is_halted;
    logic [AW-1:0]              dbg_addr;
    logic [XLEN-1:0]            dbg_data;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, is_ecall, dbg_addr,
        input  rs_dout, rs_busy, is_halted, dbg_data
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, is_ecall, dbg_addr,
        output rs_dout, rs_busy, is_halted, dbg_data
    );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, optional forwarding, busy flag.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [AW-1:0]                addr,
    input  logic [NREGS-1:0][XLEN-1:0]   rf_view,
    input  logic [NREGS-1:0]             pending,
    input  logic                         byp_valid,
    input  logic [AW-1:0]                byp_addr,
    input  logic [XLEN-1:0]              byp_data,
    output logic [XLEN-1:0]              dout,
    output logic                         busy
);

    logic hit_s;

    // Select zero, forwarded writeback data or array contents.
    always_comb begin
        hit_s = BYPASS_EN && byp_valid && (addr == byp_addr);
        dout  = {XLEN{1'b0}};
        busy  = 1'b0;
        if (addr == {AW{1'b0}}) begin
            dout = {XLEN{1'b0}};
            busy = 1'b0;
        end else if (hit_s) begin
            // The producer is completing right now, so the value is already valid.
            dout = byp_data;
            busy = 1'b0;
        end else begin
            dout = rf_view[addr];
            busy = pending[addr];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending bits and a sticky ECALL halt flag.
// Build option: REGFILE_BYPASS_EN forwards the writeback value to reads and the halt check.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int          XLEN       = XLEN_DEF,
    parameter int          NREGS      = NREGS_DEF,
    parameter int          NUM_RPORTS = NUM_RPORTS_DEF,
    parameter int          SP_INDEX   = SP_INDEX_DEF,
    parameter int unsigned SP_INIT    = SP_INIT_DEF,
    parameter int          HALT_REG   = HALT_REG_DEF,
    parameter int unsigned HALT_CODE  = HALT_CODE_DEF
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);

    localparam int AW = addr_width(NREGS);

    logic [NREGS-1:0][XLEN-1:0] rf_r;
    logic [NREGS-1:0]           pending_r;
    logic [NREGS-1:0]           pending_nxt_s;
    logic [NREGS-1:0]           set_mask_s;
    logic [NREGS-1:0]           clr_mask_s;
    logic                       halted_r;
    logic                       wr_ok_s;
    logic                       iss_ok_s;
    logic                       halt_hit_s;
    logic [XLEN-1:0]            halt_val_s;
    logic [NUM_RPORTS*XLEN-1:0] rdata_s;
    logic [NUM_RPORTS-1:0]      rbusy_s;

    // Qualify write/issue, update the scoreboard and evaluate the halt condition.
    always_comb begin
        wr_ok_s    = bus.wr_en && (bus.wr_addr != {AW{1'b0}}) && !halted_r;
        iss_ok_s   = bus.iss_valid && (bus.iss_rd != {AW{1'b0}}) && !halted_r;
        clr_mask_s = wr_ok_s  ? (NREGS'(1'b1) << bus.wr_addr) : {NREGS{1'b0}};
        set_mask_s = iss_ok_s ? (NREGS'(1'b1) << bus.iss_rd)  : {NREGS{1'b0}};
        // Set is applied after clear: a same-cycle reissue keeps the register pending.
        pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
        halt_val_s = (BYPASS_EN && wr_ok_s && (bus.wr_addr == AW'(HALT_REG)))
                   ? bus.wr_data : rf_r[HALT_REG];
        halt_hit_s = bus.is_ecall && (halt_val_s == XLEN'(HALT_CODE));
    end

    // Architectural state: array, pending bits and sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_r           <= '0;
            rf_r[SP_INDEX] <= XLEN'(SP_INIT);
            pending_r      <= {NREGS{1'b0}};
            halted_r       <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                rf_r[bus.wr_addr] <= bus.wr_data;
            end
            pending_r <= pending_nxt_s;
            halted_r  <= halted_r | halt_hit_s;
        end
    end

    for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_rport
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .addr      (bus.rs_addr[i*AW +: AW]),
            .rf_view   (rf_r),
            .pending   (pending_r),
            .byp_valid (wr_ok_s),
            .byp_addr  (bus.wr_addr),
            .byp_data  (bus.wr_data),
            .dout      (rdata_s[i*XLEN +: XLEN]),
            .busy      (rbusy_s[i])
        );
    end

    assign bus.rs_dout   = rdata_s;
    assign bus.rs_busy   = rbusy_s;
    assign bus.is_halted = halted_r;
    assign bus.dbg_data  = rf_r[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations queue up with stimulus and a
// negedge monitor compares them against the DUT outputs.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NP   = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_DOUT = 0;
    localparam int K_BUSY = 1;
    localparam int K_HALT = 2;
    localparam int K_DBG  = 3;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    exp_t cur;
    logic [31:0] act;
    int total;
    int bad;

    regfile_if #(.XLEN(XLEN), .AW(AW), .NUM_RPORTS(NP)) bus ();

    regfile_scoreboard #(
        .XLEN       (XLEN),
        .NREGS      (32),
        .NUM_RPORTS (NP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge, pop all queued expectations and compare.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            case (cur.kind)
                K_DOUT:  act = bus.rs_dout[cur.port*XLEN +: XLEN];
                K_BUSY:  act = {31'b0, bus.rs_busy[cur.port]};
                K_HALT:  act = {31'b0, bus.is_halted};
                default: act = bus.dbg_data;
            endcase
            total++;
            if (act !== cur.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int port, input int a);
        bus.rs_addr[port*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'h0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.is_ecall  = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
    endtask

    task automatic iss(input int a);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = AW'(a);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        bus.rs_addr  = '0;
        bus.dbg_addr = 5'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset contents of every register, through port 0 and the debug port.
        for (int a = 0; a < 32; a++) begin
            rd(0, a);
            bus.dbg_addr = AW'(a);
            chk("rst_dout", K_DOUT, 0, (a == 2) ? 32'h0000_2ffc : 32'h0);
            chk("rst_busy", K_BUSY, 0, 32'h0);
            chk("rst_dbg", K_DBG, 0, (a == 2) ? 32'h0000_2ffc : 32'h0);
            tick();
        end
        chk("rst_halt", K_HALT, 0, 32'h0);

        // Write x5, visible next cycle (or same cycle with forwarding).
        wr(5, 32'hDEAD_BEEF); rd(0, 5);
        chk("wr5_same", K_DOUT, 0, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick(); idle();
        chk("wr5_next", K_DOUT, 0, 32'hDEAD_BEEF);
        tick();

        // Writes to x0 are dropped.
        wr(0, 32'h1234); rd(0, 0);
        chk("wr0_same", K_DOUT, 0, 32'h0);
        tick(); idle(); bus.dbg_addr = 5'd0;
        chk("wr0_next", K_DOUT, 0, 32'h0);
        chk("wr0_dbg", K_DBG, 0, 32'h0);
        tick();

        // Issue x7 sets the pending bit from the next cycle on.
        iss(7); rd(1, 7);
        chk("iss7_same", K_BUSY, 1, 32'h0);
        tick(); idle(); rd(0, 7);
        chk("iss7_busy1", K_BUSY, 1, 32'h1);
        chk("iss7_busy0", K_BUSY, 0, 32'h1);
        tick();

        // Writeback x7 clears the pending bit.
        wr(7, 32'h55);
        chk("wb7_busy_same", K_BUSY, 1, BYP ? 32'h0 : 32'h1);
        chk("wb7_dout_same", K_DOUT, 1, BYP ? 32'h55 : 32'h0);
        tick(); idle();
        chk("wb7_busy", K_BUSY, 1, 32'h0);
        chk("wb7_dout", K_DOUT, 1, 32'h55);
        tick();

        // Issue and write to the same register: the new producer keeps it pending.
        iss(7); wr(7, 32'h66);
        tick(); idle();
        chk("same_busy", K_BUSY, 1, 32'h1);
        chk("same_dout", K_DOUT, 1, 32'h66);
        tick();
        wr(7, 32'h77);
        tick(); idle();
        chk("clr7_busy", K_BUSY, 1, 32'h0);
        tick();

        // Forwarding window on port 1.
        wr(9, 32'hA5); rd(1, 9);
        chk("byp9_same", K_DOUT, 1, BYP ? 32'hA5 : 32'h0);
        chk("byp9_busy", K_BUSY, 1, 32'h0);
        tick(); idle();
        chk("byp9_next", K_DOUT, 1, 32'hA5);
        tick();

        // Issue and write to different registers in one cycle.
        iss(10); wr(11, 32'h3);
        tick(); idle(); rd(0, 10); rd(1, 11);
        chk("diff_busy10", K_BUSY, 0, 32'h1);
        chk("diff_dout11", K_DOUT, 1, 32'h3);
        chk("diff_busy11", K_BUSY, 1, 32'h0);
        tick();

        // Writeback to a pending register while it is being read.
        iss(12);
        tick(); idle(); wr(12, 32'hC); rd(0, 12);
        chk("wb12_busy_same", K_BUSY, 0, BYP ? 32'h0 : 32'h1);
        tick(); idle();
        chk("wb12_busy", K_BUSY, 0, 32'h0);
        chk("wb12_dout", K_DOUT, 0, 32'hC);
        tick();

        // Issue to x0 never marks it busy.
        iss(0); rd(0, 0);
        tick(); idle();
        chk("iss0_busy", K_BUSY, 0, 32'h0);
        tick();

        // ECALL with a7=9 does not halt.
        wr(17, 32'd9);
        tick(); idle(); bus.is_ecall = 1'b1;
        tick(); idle();
        chk("ecall9_halt", K_HALT, 0, 32'h0);
        tick();

        // ECALL with a7=10 halts on the next edge.
        wr(17, 32'd10);
        tick(); idle(); bus.is_ecall = 1'b1;
        chk("ecall10_pre", K_HALT, 0, 32'h0);
        tick(); idle();
        chk("ecall10_halt", K_HALT, 0, 32'h1);
        tick();

        // Halted: writes and issues are ignored, reads continue.
        wr(3, 32'h1); iss(13);
        tick(); idle(); rd(0, 3); rd(1, 17);
        chk("halt_wr3", K_DOUT, 0, 32'h0);
        chk("halt_rd17", K_DOUT, 1, 32'd10);
        chk("halt_sticky", K_HALT, 0, 32'h1);
        tick();
        rd(0, 13); rd(1, 10);
        chk("halt_iss13", K_BUSY, 0, 32'h0);
        chk("halt_busy10", K_BUSY, 1, 32'h1);
        tick();

        // Reset wins over simultaneous write, issue and halting ECALL.
        reset = 1'b1; wr(2, 32'hFFFF); iss(4); bus.is_ecall = 1'b1;
        tick(); reset = 1'b0; idle(); rd(0, 2); rd(1, 4);
        chk("rp_x2", K_DOUT, 0, 32'h0000_2ffc);
        chk("rp_busy4", K_BUSY, 1, 32'h0);
        chk("rp_halt", K_HALT, 0, 32'h0);
        tick();
        rd(0, 17); rd(1, 10);
        chk("rp_x17", K_DOUT, 0, 32'h0);
        chk("rp_busy10", K_BUSY, 1, 32'h0);
        tick();

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle CPU register file, for the pipelined RISC-V core.
- Provides N asynchronous read ports, one synchronous write port, and a per-register pending (scoreboard) bit set at issue and cleared at writeback.
- Also provides a registered, sticky ECALL halt flag.
- Sits between decode/issue (reads, issue, hazard check) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 32. AW = $clog2(NREGS).
- NUM_RPORTS, 2, number of read ports; range 1..4.
- SP_INDEX, 2, register loaded with SP_INIT on reset.
- SP_INIT, 32'h2ffc, reset value of the stack pointer.
- HALT_REG, 17, register checked at ECALL (a7).
- HALT_CODE, 10, value of HALT_REG that halts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_addr  in  NUM_RPORTS*AW  read addresses; port i = bits [i*AW +: AW].
- rs_dout  out  NUM_RPORTS*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rs_busy  out  NUM_RPORTS  port i reads a register with a pending write.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_valid  in  1  an instruction writing iss_rd issues this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- is_ecall  in  1  ECALL in decode this cycle.
- is_halted  out  1  registered, sticky halt flag.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; raw array, never bypassed.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset (on the edge where reset=1):
  - all registers set to 0, except rf[SP_INDEX] = SP_INIT;
  - all pending bits set to 0;
  - is_halted set to 0.
  - Reset overrides every other input in that cycle, including a simultaneous write, issue or ECALL.
- Register 0:
  - always reads 0;
  - writes to address 0 are ignored;
  - issue to address 0 never sets a pending bit, so busy for address 0 is always 0.
- Write: on the rising edge, when wr_en=1, wr_addr!=0 and is_halted=0, rf[wr_addr] <= wr_data. Latency is 1 edge to the array.
- Reads: combinational from rs_addr, with zero latency. Any number of ports may read the same address.
- Pending bits, updated on each edge:
  - Issue (iss_valid=1, iss_rd!=0, is_halted=0) sets pending[iss_rd].
  - Write (wr_en=1, wr_addr!=0, is_halted=0) clears pending[wr_addr].
  - Issue and write to the same register in the same cycle: pending stays set, because the newer producer wins.
  - Issue and write to different registers in the same cycle: both take effect.
  - A write to a non-pending register is legal; its clear is a no-op.
- rs_busy[i] = pending[rs_addr_i] AND NOT (bypass hit on port i).
- Halt:
  - If is_ecall=1 and the effective value of HALT_REG (bypassed when the feature is enabled) equals HALT_CODE, is_halted <= 1 on the next edge.
  - is_halted stays 1 until reset.
  - While halted, writes and issues are ignored and reads continue.
  - ECALL with any other value has no effect.
- Widths: a HALT_CODE comparison zero-extends to XLEN. Addresses are AW bits wide and are never out of range.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr!=0, is_halted=0 and rs_addr_i==wr_addr, rs_dout_i = wr_data and rs_busy[i]=0 in that same cycle (write-to-read forwarding).
  - The HALT_REG check also uses the forwarded value.
- Undefined:
  - Reads return array contents only; the new value is visible the cycle after the write edge.
  - rs_busy follows the pending bit with no exception.

Decomposition:
- Package regfile_pkg holds:
  - XLEN/NREGS defaults;
  - SP_INDEX, SP_INIT, HALT_REG, HALT_CODE;
  - the localparam for AW derivation.
- One sub-module, regfile_read_port: a single read port (address, array view, bypass inputs → dout, busy). It is instantiated NUM_RPORTS times with a generate loop.
- The top level owns the array, the scoreboard and the halt flag.

Test Plan:
- Reset: hold reset for 1 edge → every rs_dout reads 0, except address 2 reads 32'h2ffc; rs_busy=0; is_halted=0.
- Write then read: write x5=32'hDEADBEEF → next cycle port0 reads 32'hDEADBEEF. Write x0=32'h1234 → x0 still reads 0.
- Scoreboard: issue rd=7 → rs_busy=1 for a port reading x7. Writeback x7=32'h55 → busy=0 the next cycle and data=32'h55. Issue and write x7 in the same cycle → busy remains 1.
- Bypass: write x9=32'hA5 with port1 reading x9 in the same cycle.
  - With REGFILE_BYPASS_EN: rs_dout1=32'hA5 and busy=0 in that cycle.
  - Without it: the old value that cycle and 32'hA5 the next.
- Halt:
  - Write x17=10, then is_ecall=1 → is_halted=1 the next edge.
  - A later write x3=32'h1 is ignored (x3 still reads 0).
  - ECALL with x17=9 → is_halted stays 0.
- Reset priority: reset asserted together with wr_en (x2=32'hFFFF), iss_valid (rd=4) and a halting ECALL → x2=32'h2ffc, pending[4]=0, is_halted=0.
